// File: rtl/led_pattern_gen.sv
// Parametrised LED sequencer: FILL / CHASE / BOUNCE / FILL_DRAIN patterns, one step per DIV clocks.
// Define LED_PATTERN_ACTIVE_LOW_EN to drive inverted (active-low) LED outputs.

module led_pattern_lane #(
  parameter int IDX = 0,
  parameter int N_W = 4
) (
  input  logic           fill_i,
  input  logic [N_W-1:0] n_i,
  output logic           led_o
);
  localparam logic [N_W-1:0] IDX_N = N_W'(IDX);

  // Fill masks light every lane below the count; one-hot patterns light only lane n.
  assign led_o = fill_i ? (IDX_N < n_i) : (IDX_N == n_i);
endmodule

module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             cycle_done
);
  localparam int STEP_W = $clog2(2*WIDTH);
  localparam int N_W    = STEP_W + 1;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV-1);
  localparam logic [N_W-1:0] W_N        = N_W'(WIDTH);
  localparam logic [N_W-1:0] W2_N       = N_W'(2*WIDTH);
  localparam logic [N_W-1:0] W2M2_N     = N_W'(2*WIDTH-2);

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    M_FILL       = 2'd0,
    M_CHASE      = 2'd1,
    M_BOUNCE     = 2'd2,
    M_FILL_DRAIN = 2'd3
  } mode_e;

  typedef struct packed {
    logic           fill;
    logic [N_W-1:0] n;
  } pat_t;

  function automatic logic [STEP_W-1:0] last_step(input mode_e m);
    logic [STEP_W-1:0] r;
    case (m)
      M_FILL:   r = STEP_W'(WIDTH);
      M_CHASE:  r = STEP_W'(WIDTH-1);
      M_BOUNCE: r = STEP_W'(2*WIDTH-3);
      default:  r = STEP_W'(2*WIDTH-1);
    endcase
    return r;
  endfunction

  // Reduce (mode, step) to a fill-or-onehot flag plus a bit count / position.
  function automatic pat_t pat_of(input mode_e m, input logic [STEP_W-1:0] s);
    pat_t             p;
    logic [N_W-1:0]   s_n;
    s_n = {1'b0, s};
    case (m)
      M_FILL:   begin p.fill = 1'b1; p.n = s_n; end
      M_CHASE:  begin p.fill = 1'b0; p.n = s_n; end
      M_BOUNCE: begin p.fill = 1'b0; p.n = (s_n < W_N) ? s_n : (W2M2_N - s_n); end
      default:  begin p.fill = 1'b1; p.n = (s_n <= W_N) ? s_n : (W2_N - s_n); end
    endcase
    return p;
  endfunction

  mode_e             mode_q, mode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              cyc_q, cyc_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              tick;
  mode_e             mode_in;
  pat_t              pat;
  logic [WIDTH-1:0]  pat_bits;

  assign mode_in = mode_e'(mode);
  assign tick    = enable && (presc_q == PRESC_LAST);

  // Mode change wins over tick and over enable low.
  always_comb begin
    mode_d  = mode_q;
    step_d  = step_q;
    presc_d = presc_q;
    cyc_d   = 1'b0;
    if (mode_in != mode_q) begin
      mode_d  = mode_in;
      step_d  = '0;
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (step_q == last_step(mode_q)) begin
        step_d = '0;
        cyc_d  = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end else if (enable) begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign pat = pat_of(mode_d, step_d);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    led_pattern_lane #(.IDX(i), .N_W(N_W)) u_lane (
      .fill_i (pat.fill),
      .n_i    (pat.n),
      .led_o  (pat_bits[i])
    );
  end

  assign out_d = pat_bits ^ {WIDTH{INV}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= M_FILL;
      step_q  <= '0;
      presc_q <= '0;
      cyc_q   <= 1'b0;
      out_q   <= {WIDTH{INV}};
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      cyc_q   <= cyc_d;
      out_q   <= out_d;
    end
  end

  assign out        = out_q;
  assign cycle_done = cyc_q;
endmodule
